controller_nes: RTL and testbench
=================================

CONTROLLER_NES -- requirements
Module: controller_nes

Interface
REQ-001 Parameter LATCH_CYCLES, default 1200, latch pulse width in clk cycles (12 us at 100 MHz); legal minimum 3.
REQ-002 Parameter PULSE_HALF_CYCLES, default 600, high and low width of each pulse_out phase in clk cycles (6 us at 100 MHz); legal minimum 2.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  level request; high while idle begins a read cycle.
REQ-006 data_in  input  1  serial data from the NES pad (4021 shift register); active-low, 0 = button pressed; asynchronous to clk.
REQ-007 latch_out  output  1  registered; drives the pad LATCH pin.
REQ-008 pulse_out  output  1  registered; drives the pad CLOCK pin.
REQ-009 buttons_pressed  output  8  registered; 1 = pressed; bit0 A, bit1 B, bit2 Select, bit3 Start, bit4 Up, bit5 Down, bit6 Left, bit7 Right.

Function
REQ-010 data_in SHALL pass through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-011 States: IDLE, LATCH, PULSE_HIGH, PULSE_LOW, DONE.
REQ-012 IDLE: latch_out=0, pulse_out=0; start=1 sampled at edge t0 moves to LATCH, so latch_out=1 from t0+1.
REQ-013 LATCH: latch_out=1 for exactly LATCH_CYCLES cycles; on its last cycle, the inverted synchronized data_in is captured into shadow bit0.
REQ-014 After LATCH, exactly 8 pulses follow; each pulse is PULSE_HIGH (pulse_out=1, PULSE_HALF_CYCLES cycles), then PULSE_LOW (pulse_out=0, PULSE_HALF_CYCLES cycles); latch_out=0 throughout.
REQ-015 On the last cycle of PULSE_LOW for pulse n (n=1..7), the inverted synchronized data_in is captured into shadow bit n; nothing is sampled after pulse 8.
REQ-016 After pulse 8's low phase, DONE lasts one cycle and copies the whole shadow register into buttons_pressed atomically; buttons_pressed changes only here.
REQ-017 buttons_pressed therefore updates at edge t0+LATCH_CYCLES+16*PULSE_HALF_CYCLES+1 and holds until the next DONE.
REQ-018 DONE always returns to IDLE; if start is still high, the next LATCH begins one cycle later, giving continuous polling.
REQ-019 start is ignored outside IDLE; deasserting it mid-read does not abort the cycle.
REQ-020 Phase and bit counters are sized for the parameter values and SHALL not wrap within a phase; the bit counter ranges 0..8.

Reset
REQ-021 rst_n=0 asynchronously forces IDLE, latch_out=0, pulse_out=0, buttons_pressed=8'h00, shadow=0, synchronizer flops=1 (released), counters=0.
REQ-022 Reset asserted mid-read aborts the read immediately; buttons_pressed is not updated from the partial shadow; operation resumes only on a new start after rst_n=1.

Verification (LATCH_CYCLES=4, PULSE_HALF_CYCLES=2, 10 ns clk; pad model shifts on pulse_out rising edge)
REQ-023 Reset then start=0 for 20 cycles -> latch_out=0, pulse_out=0, buttons_pressed=8'h00 throughout.
REQ-024 Pad holds A only pressed; single start pulse -> latch_out high 4 cycles, 8 pulses of 2 high/2 low, buttons_pressed=8'h01 at t0+37, then IDLE with both outputs low.
REQ-025 Pad serial stream 0,1,1,1,1,1,1,0 (A and Right pressed) -> buttons_pressed=8'h81; pad all ones -> 8'h00 on the following read.
REQ-026 start held high continuously -> latch rises again at t0+38; period 37 cycles; buttons_pressed tracks pad changes once per period.
REQ-027 rst_n low during pulse 4 -> outputs 0 within the same cycle; buttons_pressed keeps 8'h00 and does not take partial data; a new start performs a full correct read.
REQ-028 start deasserted during LATCH -> read completes all 8 pulses and updates buttons_pressed; start toggled during pulses has no effect on timing.

Source files
------------

// File: rtl/controller_nes.sv
`default_nettype none
// ============================================================================
// Module   : controller_nes
// Purpose  : Polls an NES game pad. The pad contains a 4021 parallel-in /
//            serial-out register. The block pulses LATCH, then clocks the
//            eight button bits out with eight CLOCK pulses. It presents the
//            decoded button set as one atomically updated byte.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   LATCH_CYCLES      : latch pulse width in clk cycles (>= 3)
//   PULSE_HALF_CYCLES : high and low width of each CLOCK pulse phase (>= 2)
// Ports
//   clk             in   sole clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   start           in   level request; sampled only when no read is running
//   data_in         in   pad serial data, active-low, asynchronous to clk
//   latch_out       out  registered pad LATCH
//   pulse_out       out  registered pad CLOCK
//   buttons_pressed out  registered button set, 1 = pressed
//                        (A, B, Select, Start, Up, Down, Left, Right = bit0..7)
// ============================================================================
module controller_nes #(
  parameter int LATCH_CYCLES      = 1200,
  parameter int PULSE_HALF_CYCLES = 600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       data_in,
  output logic       latch_out,
  output logic       pulse_out,
  output logic [7:0] buttons_pressed
);

  // The phase counter only has to reach the longest phase length minus one.
  localparam int c_PHASE_MAX = (LATCH_CYCLES > PULSE_HALF_CYCLES) ?
                               LATCH_CYCLES : PULSE_HALF_CYCLES;
  localparam int c_CNT_W     = $clog2(c_PHASE_MAX);

  localparam logic [c_CNT_W-1:0] c_LATCH_LAST = c_CNT_W'(LATCH_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_HALF_LAST  = c_CNT_W'(PULSE_HALF_CYCLES - 1);
  localparam logic [3:0]         c_LAST_PULSE = 4'd7;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LATCH      = 3'd1,
    PULSE_HIGH = 3'd2,
    PULSE_LOW  = 3'd3,
    DONE       = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [c_CNT_W-1:0] r_phase_cnt;
  logic [3:0]         r_bit_cnt;      // pulses completed, 0..8
  logic [1:0]         r_sync;         // r_sync[1] is the usable sample
  logic [7:0]         r_shadow;
  logic               r_latch;
  logic               r_pulse;
  logic [7:0]         r_buttons;

  logic               w_phase_last;
  logic               w_sample;
  logic [2:0]         w_bit_idx;

  assign latch_out       = r_latch;
  assign pulse_out       = r_pulse;
  assign buttons_pressed = r_buttons;

  // Pad data is active-low: a 0 on the line means the button is pressed.
  assign w_sample  = ~r_sync[1];
  // Pulse n (1..7) delivers bit n. r_bit_cnt holds n-1 during pulse n.
  assign w_bit_idx = r_bit_cnt[2:0] + 3'd1;

  // --------------------------------------------------------------------------
  // Last cycle of the current timed phase
  // --------------------------------------------------------------------------
  always_comb begin
    w_phase_last = 1'b0;
    case (r_state)
      LATCH:                 w_phase_last = (r_phase_cnt == c_LATCH_LAST);
      PULSE_HIGH, PULSE_LOW: w_phase_last = (r_phase_cnt == c_HALF_LAST);
      default:               w_phase_last = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  // DONE also acts as the idle decision cycle. A start that is still high
  // there launches the next latch directly. Continuous polling therefore
  // repeats every LATCH_CYCLES + 16*PULSE_HALF_CYCLES + 1 cycles. A low start
  // parks the machine in IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = LATCH;
      end
      LATCH: begin
        if (w_phase_last) w_state_next = PULSE_HIGH;
      end
      PULSE_HIGH: begin
        if (w_phase_last) w_state_next = PULSE_LOW;
      end
      PULSE_LOW: begin
        if (w_phase_last) begin
          w_state_next = (r_bit_cnt == c_LAST_PULSE) ? DONE : PULSE_HIGH;
        end
      end
      DONE: begin
        w_state_next = start ? LATCH : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State register and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_phase_cnt <= '0;
      r_bit_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;

      // Every phase starts counting from zero. The counter is idle outside
      // the timed phases.
      if ((w_state_next != r_state) || (r_state == IDLE) || (r_state == DONE)) begin
        r_phase_cnt <= '0;
      end else begin
        r_phase_cnt <= r_phase_cnt + 1'b1;
      end

      if (r_state == DONE) begin
        r_bit_cnt <= 4'd0;
      end else if ((r_state == PULSE_LOW) && w_phase_last) begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Input synchronizer. Reset value is the released (not pressed) level.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], data_in};
    end
  end

  // --------------------------------------------------------------------------
  // Shadow capture
  // --------------------------------------------------------------------------
  // The 4021 presents bit0 while LATCH is high. After each CLOCK rising edge
  // it presents the next bit. Sampling at the end of each low phase gives
  // the synchronizer the whole pulse period to settle. Nothing is sampled
  // after the eighth pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= 8'h00;
    end else if ((r_state == LATCH) && w_phase_last) begin
      r_shadow[0] <= w_sample;
    end else if ((r_state == PULSE_LOW) && w_phase_last && (r_bit_cnt < c_LAST_PULSE)) begin
      r_shadow[w_bit_idx] <= w_sample;
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs (one cycle behind the state)
  // --------------------------------------------------------------------------
  // The button byte changes only when a read has completed. A read aborted
  // by reset never reaches DONE, so partial data is never exposed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_latch   <= 1'b0;
      r_pulse   <= 1'b0;
      r_buttons <= 8'h00;
    end else begin
      r_latch <= (r_state == LATCH);
      r_pulse <= (r_state == PULSE_HIGH);
      if (r_state == DONE) begin
        r_buttons <= r_shadow;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_controller_nes.sv
`default_nettype none
// ============================================================================
// Module   : tb_controller_nes
// Purpose  : Self-checking bench for controller_nes. A 4021 pad model feeds
//            the serial line. Expected waveforms and button bytes come from
//            the read-cycle timing rules and from the pad contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_controller_nes;

  localparam int L = 4;                // latch width
  localparam int H = 2;                // pulse half width
  localparam int P = L + 16 * H + 1;   // read period under continuous polling

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       data_in;
  logic       latch_out;
  logic       pulse_out;
  logic [7:0] buttons_pressed;

  int checks = 0;
  int errors = 0;

  controller_nes #(
    .LATCH_CYCLES      (L),
    .PULSE_HALF_CYCLES (H)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .data_in         (data_in),
    .latch_out       (latch_out),
    .pulse_out       (pulse_out),
    .buttons_pressed (buttons_pressed)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Pad model: LATCH loads the parallel value and shows bit0. Each CLOCK
  // rising edge shifts to the next bit. The serial input is tied high, so
  // ones appear after bit7.
  // --------------------------------------------------------------------------
  logic [7:0] pad_stream;              // bit k = level presented for button k
  int         pad_idx = 8;

  always @(posedge latch_out) pad_idx = 0;
  always @(posedge pulse_out) if (pad_idx < 8) pad_idx = pad_idx + 1;
  assign data_in = (pad_idx < 8) ? pad_stream[pad_idx[2:0]] : 1'b1;

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  logic [7:0] rd_stream [4];           // pad contents for each read of a capture
  logic [7:0] prev_btn;                // button byte before the capture began

  logic       lat_q [0:199];
  logic       pul_q [0:199];
  logic [7:0] btn_q [0:199];

  // k counts clock edges after the edge that sampled start.
  function automatic logic exp_latch(input int k, input int nreads);
    int r;
    if (k < 1 || (k - 1) / P >= nreads) return 1'b0;
    r = (k - 1) % P + 1;
    return (r <= L);
  endfunction

  function automatic logic exp_pulse(input int k, input int nreads);
    int r;
    if (k < 1 || (k - 1) / P >= nreads) return 1'b0;
    r = (k - 1) % P + 1;
    if (r < L + 1 || r > L + 16 * H) return 1'b0;
    return (((r - L - 1) / H) % 2) == 0;
  endfunction

  function automatic logic [7:0] exp_btn(input int k, input int nreads);
    int done;
    done = k / P;
    if (done > nreads) done = nreads;
    if (done == 0) return prev_btn;
    return ~rd_stream[done - 1];
  endfunction

  // Launch a read at the next edge and record ncyc cycles of outputs.
  // Start behaviour during the capture:
  //   mode 0 - single start pulse
  //   mode 1 - start held through the first LATCH cycles, then dropped
  //   mode 2 - start random during the pulse train
  //   mode 3 - start held for nreads back-to-back reads, with the pad
  //            contents changed between reads
  task automatic capture(input int ncyc, input int mode, input int nreads);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = (mode == 1 || mode == 3) ? 1'b1 : 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk);
      #1;
      lat_q[k] = latch_out;
      pul_q[k] = pulse_out;
      btn_q[k] = buttons_pressed;
      case (mode)
        1:       start = (k < 2);
        2:       start = (k >= 4 && k <= 35) ? 1'($urandom_range(0, 1)) : 1'b0;
        3: begin
          start = (k < nreads * P - 1);
          // Change the pad after the last sample of a read and before the
          // next latch.
          if ((k % P) == P - 3 && (k / P + 1) < nreads) pad_stream = rd_stream[k / P + 1];
        end
        default: start = 1'b0;
      endcase
    end
    start = 1'b0;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    prev_btn = 8'h00;
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset;
    apply_reset();
    #1;
    checks++;
    if (latch_out !== 1'b0 || pulse_out !== 1'b0 || buttons_pressed !== 8'h00) begin
      errors++;
      $display("FAIL reset_state latch=%b pulse=%b buttons=%h expected 0 0 00",
               latch_out, pulse_out, buttons_pressed);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (latch_out !== 1'b0 || pulse_out !== 1'b0 || buttons_pressed !== 8'h00) begin
        errors++;
        $display("FAIL idle_cycle%0d latch=%b pulse=%b buttons=%h expected 0 0 00",
                 i, latch_out, pulse_out, buttons_pressed);
      end
    end
  endtask

  task automatic test_known_patterns;
    logic [7:0] pats [3];
    pats[0] = 8'hFE;   // A only
    pats[1] = 8'h7E;   // serial 0,1,1,1,1,1,1,0 : A and Right
    pats[2] = 8'hFF;   // nothing pressed
    for (int p = 0; p < 3; p++) begin
      rd_stream[0] = pats[p];
      pad_stream   = pats[p];
      capture(40, 0, 1);
      for (int k = 1; k <= 40; k++) begin
        checks++;
        if (lat_q[k] !== exp_latch(k, 1) || pul_q[k] !== exp_pulse(k, 1) ||
            btn_q[k] !== exp_btn(k, 1)) begin
          errors++;
          $display("FAIL pattern%0d k=%0d latch/pulse/buttons got %b %b %h expected %b %b %h",
                   p, k, lat_q[k], pul_q[k], btn_q[k], exp_latch(k, 1), exp_pulse(k, 1), exp_btn(k, 1));
        end
      end
      prev_btn = ~pats[p];
    end
  endtask

  task automatic test_random_reads;
    for (int n = 0; n < 6; n++) begin
      rd_stream[0] = 8'($urandom);
      pad_stream   = rd_stream[0];
      capture(40, 0, 1);
      for (int k = 1; k <= 40; k++) begin
        checks++;
        if (lat_q[k] !== exp_latch(k, 1) || pul_q[k] !== exp_pulse(k, 1) ||
            btn_q[k] !== exp_btn(k, 1)) begin
          errors++;
          $display("FAIL random_read%0d k=%0d latch/pulse/buttons got %b %b %h expected %b %b %h",
                   n, k, lat_q[k], pul_q[k], btn_q[k], exp_latch(k, 1), exp_pulse(k, 1), exp_btn(k, 1));
        end
      end
      prev_btn = ~rd_stream[0];
    end
  endtask

  task automatic test_start_behaviour;
    for (int m = 1; m <= 2; m++) begin
      rd_stream[0] = 8'($urandom);
      pad_stream   = rd_stream[0];
      capture(40, m, 1);
      for (int k = 1; k <= 40; k++) begin
        checks++;
        if (lat_q[k] !== exp_latch(k, 1) || pul_q[k] !== exp_pulse(k, 1) ||
            btn_q[k] !== exp_btn(k, 1)) begin
          errors++;
          $display("FAIL start_mode%0d k=%0d latch/pulse/buttons got %b %b %h expected %b %b %h",
                   m, k, lat_q[k], pul_q[k], btn_q[k], exp_latch(k, 1), exp_pulse(k, 1), exp_btn(k, 1));
        end
      end
      prev_btn = ~rd_stream[0];
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) rd_stream[i] = 8'($urandom);
    pad_stream = rd_stream[0];
    capture(3 * P + 3, 3, 3);
    for (int k = 1; k <= 3 * P + 3; k++) begin
      checks++;
      if (lat_q[k] !== exp_latch(k, 3) || pul_q[k] !== exp_pulse(k, 3) ||
          btn_q[k] !== exp_btn(k, 3)) begin
        errors++;
        $display("FAIL back_to_back k=%0d latch/pulse/buttons got %b %b %h expected %b %b %h",
                 k, lat_q[k], pul_q[k], btn_q[k], exp_latch(k, 3), exp_pulse(k, 3), exp_btn(k, 3));
      end
    end
    prev_btn = ~rd_stream[2];
  endtask

  task automatic test_reset_mid_read;
    apply_reset();
    pad_stream = 8'($urandom) & 8'h7F;   // at least one press so partial data is visible
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (17) @(posedge clk);          // high phase of pulse 4
    #1;
    checks++;
    if (pulse_out !== 1'b1) begin
      errors++;
      $display("FAIL pulse4_high pulse=%b expected 1", pulse_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (latch_out !== 1'b0 || pulse_out !== 1'b0 || buttons_pressed !== 8'h00) begin
      errors++;
      $display("FAIL async_abort latch=%b pulse=%b buttons=%h expected 0 0 00",
               latch_out, pulse_out, buttons_pressed);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (latch_out !== 1'b0 || pulse_out !== 1'b0 || buttons_pressed !== 8'h00) begin
        errors++;
        $display("FAIL post_abort_idle%0d latch=%b pulse=%b buttons=%h expected 0 0 00",
                 i, latch_out, pulse_out, buttons_pressed);
      end
    end
    rd_stream[0] = 8'($urandom);
    pad_stream   = rd_stream[0];
    capture(40, 0, 1);
    for (int k = 1; k <= 40; k++) begin
      checks++;
      if (lat_q[k] !== exp_latch(k, 1) || pul_q[k] !== exp_pulse(k, 1) ||
          btn_q[k] !== exp_btn(k, 1)) begin
        errors++;
        $display("FAIL read_after_abort k=%0d latch/pulse/buttons got %b %b %h expected %b %b %h",
                 k, lat_q[k], pul_q[k], btn_q[k], exp_latch(k, 1), exp_pulse(k, 1), exp_btn(k, 1));
      end
    end
    prev_btn = ~rd_stream[0];
  endtask

  // --------------------------------------------------------------------------
  // Sequencer and watchdog
  // --------------------------------------------------------------------------
  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    pad_stream = 8'hFF;
    prev_btn   = 8'h00;
    test_reset();
    test_known_patterns();
    test_random_reads();
    test_start_behaviour();
    test_back_to_back();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t, expected bench to finish earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
